// File: rtl/ifm_row_loader_pkg.sv
// ifm_row_loader_pkg
//   Shared widths, ring size and loader state encoding for the IFM row loader.
//   It also provides the defaults used by the CNN controller side.
package ifm_row_loader_pkg;

  localparam int W_SIZE      = 12;   // width/height field width (pixels)
  localparam int W_CHANNEL   = 10;   // tiled-channel count field width
  localparam int W_DATA      = 128;  // stream / buffer word width
  localparam int W_BUF_ADDR  = 16;   // row-buffer word address width
  localparam int IFM_BUF_CNT = 4;    // number of row buffers (power of two)
  localparam int W_IFM_BUF   = 2;    // log2(IFM_BUF_CNT)

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_WAIT_BUF = 2'd1,
    ST_LOAD     = 2'd2,
    ST_DONE     = 2'd3
  } ld_state_e;

endpackage

// File: rtl/ifm_row_loader_if.sv
// ifm_row_loader_if
//   Valid/ready word stream feeding the row loader.
//   s_valid : producer has a word on s_data
//   s_data  : IFM word, order row, col, chn (chn fastest)
//   s_ready : loader accepts the word when s_valid && s_ready
//   master = stream producer, slave = loader.
interface ifm_row_loader_if;
  import ifm_row_loader_pkg::*;

  logic              s_valid;
  logic [W_DATA-1:0] s_data;
  logic              s_ready;

  modport master (output s_valid, output s_data, input s_ready);
  modport slave  (input s_valid, input s_data, output s_ready);

endinterface

// File: rtl/ifm_buf_flags.sv
// ifm_buf_flags
//   Bank of N "buffer holds valid data" flags. A set sets flag i_set_id.
//   A release bit clears its flag at the next edge. When both hit the same
//   flag, the set wins. It is shared with the filter-buffer loader.
//   clk/rstn  : clock and asynchronous active-low reset
//   i_set     : set request, i_set_id selects the flag
//   i_release : per-flag release pulse
//   o_flags   : registered flag vector
module ifm_buf_flags #(
  parameter int N    = 4,
  parameter int W_ID = 2
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_set,
  input  logic [W_ID-1:0] i_set_id,
  input  logic [N-1:0]    i_release,
  output logic [N-1:0]    o_flags
);

  logic [N-1:0] set_vec_s;
  logic [N-1:0] flags_r;

  // Decode the set request into a one-hot vector.
  always_comb begin
    set_vec_s = {N{1'b0}};
    if (i_set) begin
      set_vec_s = N'(1'b1) << i_set_id;
    end else begin
      set_vec_s = {N{1'b0}};
    end
  end

  // Flag register: release clears first, then the set is OR-ed in so it wins.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      flags_r <= {N{1'b0}};
    end else begin
      flags_r <= (flags_r & ~i_release) | set_vec_s;
    end
  end

  assign o_flags = flags_r;

  ifm_buf_flags_chk #(.N(N)) u_chk (
    .clk     (clk),
    .rstn    (rstn),
    .set_vec (set_vec_s),
    .rel_vec (i_release)
  );

endmodule

// File: rtl/ifm_buf_flags_chk.sv
// ifm_buf_flags_chk
//   Simulation checker for the flag bank: a buffer must never be set and
//   released in the same cycle.
//   clk/rstn : clock and asynchronous active-low reset
//   set_vec  : one-hot set request
//   rel_vec  : release request
module ifm_buf_flags_chk #(
  parameter int N = 4
) (
  input logic         clk,
  input logic         rstn,
  input logic [N-1:0] set_vec,
  input logic [N-1:0] rel_vec
);

  a_no_set_release_collision : assert property (
    @(posedge clk) disable iff (!rstn) ((set_vec & rel_vec) == {N{1'b0}})
  );

endmodule

// File: rtl/ifm_row_loader.sv
// ifm_row_loader
//   Streams IFM words into a ring of IFM_BUF_CNT row buffers. Row r goes to
//   buffer r mod IFM_BUF_CNT, and o_ifm_buf_done[id] is raised once that row
//   is written completely. Loading stalls while the target buffer is still
//   held by the consumer.
//   clk, rstn                    : clock, asynchronous active-low reset
//   q_start/q_width/q_height/q_channel : frame start pulse and dimensions
//   s_if (slave)                 : input word stream
//   i_buf_release                : consumer releases buffer id
//   o_buf_we/id/addr/wdata       : registered row-buffer write port
//   o_ifm_buf_done               : per-buffer complete-row flags
//   o_load_busy / o_load_done    : frame in progress / end-of-frame pulse
module ifm_row_loader
  import ifm_row_loader_pkg::*;
(
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   q_start,
  input  logic [W_SIZE-1:0]      q_width,
  input  logic [W_SIZE-1:0]      q_height,
  input  logic [W_CHANNEL-1:0]   q_channel,
  ifm_row_loader_if.slave        s_if,
  input  logic [IFM_BUF_CNT-1:0] i_buf_release,
  output logic                   o_buf_we,
  output logic [W_IFM_BUF-1:0]   o_buf_id,
  output logic [W_BUF_ADDR-1:0]  o_buf_addr,
  output logic [W_DATA-1:0]      o_buf_wdata,
  output logic [IFM_BUF_CNT-1:0] o_ifm_buf_done,
  output logic                   o_load_busy,
  output logic                   o_load_done
);

  ld_state_e              state_r, state_s;
  logic [W_SIZE-1:0]      height_r;
  logic [W_BUF_ADDR-1:0]  row_words_r;
  logic [W_SIZE-1:0]      row_r;
  logic [W_BUF_ADDR-1:0]  addr_r;
  logic                   wr_we_r;
  logic                   wr_last_r;
  logic [W_IFM_BUF-1:0]   wr_id_r;
  logic [W_BUF_ADDR-1:0]  wr_addr_r;
  logic [W_DATA-1:0]      wr_data_r;
  logic                   done_r, done_s;
  logic [IFM_BUF_CNT-1:0] flags_s;
  logic [W_BUF_ADDR-1:0]  prod_s;
  logic [W_IFM_BUF-1:0]   cur_id_s, last_id_s;
  logic                   hs_s, last_word_s, last_row_s, buf_busy_s;

  // Product taken at address width; a frame whose row overflows it is a config error.
  assign prod_s      = W_BUF_ADDR'(q_width) * W_BUF_ADDR'(q_channel);
  assign cur_id_s    = row_r[W_IFM_BUF-1:0];
  // In ST_DONE the row counter has already moved past the last row.
  assign last_id_s   = cur_id_s - W_IFM_BUF'(1'b1);
  assign hs_s        = s_if.s_valid && (state_r == ST_LOAD);
  assign last_word_s = (addr_r == (row_words_r - W_BUF_ADDR'(1'b1)));
  assign last_row_s  = (row_r == (height_r - W_SIZE'(1'b1)));
  // A release arriving this cycle already frees the buffer.
  assign buf_busy_s  = flags_s[cur_id_s] & ~i_buf_release[cur_id_s];

  // Next-state and end-of-frame decode.
  always_comb begin
    state_s = state_r;
    done_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (q_start) state_s = ST_WAIT_BUF;
        else         state_s = ST_IDLE;
      end
      ST_WAIT_BUF: begin
        if (buf_busy_s) state_s = ST_WAIT_BUF;
        else            state_s = ST_LOAD;
      end
      ST_LOAD: begin
        if (hs_s && last_word_s) state_s = last_row_s ? ST_DONE : ST_WAIT_BUF;
        else                     state_s = ST_LOAD;
      end
      ST_DONE: begin
        if (flags_s[last_id_s]) begin
          done_s  = 1'b1;
          state_s = ST_IDLE;
        end else begin
          state_s = ST_DONE;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_r <= ST_IDLE;
    else       state_r <= state_s;
  end

  // Frame config, row/word counters, write-port register and done pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      height_r    <= {W_SIZE{1'b0}};
      row_words_r <= {W_BUF_ADDR{1'b0}};
      row_r       <= {W_SIZE{1'b0}};
      addr_r      <= {W_BUF_ADDR{1'b0}};
      wr_we_r     <= 1'b0;
      wr_last_r   <= 1'b0;
      wr_id_r     <= {W_IFM_BUF{1'b0}};
      wr_addr_r   <= {W_BUF_ADDR{1'b0}};
      wr_data_r   <= {W_DATA{1'b0}};
      done_r      <= 1'b0;
    end else begin
      done_r  <= done_s;
      wr_we_r <= hs_s;
      if ((state_r == ST_IDLE) && q_start) begin
        height_r    <= q_height;
        row_words_r <= prod_s;
        row_r       <= {W_SIZE{1'b0}};
        addr_r      <= {W_BUF_ADDR{1'b0}};
      end
      if (hs_s) begin
        wr_id_r   <= cur_id_s;
        wr_addr_r <= addr_r;
        wr_data_r <= s_if.s_data;
        wr_last_r <= last_word_s;
        if (last_word_s) begin
          addr_r <= {W_BUF_ADDR{1'b0}};
          row_r  <= row_r + W_SIZE'(1'b1);
        end else begin
          addr_r <= addr_r + W_BUF_ADDR'(1'b1);
        end
      end
    end
  end

  // The flag is set while the row's last word is on the write port, so memory precedes flag.
  ifm_buf_flags #(.N(IFM_BUF_CNT), .W_ID(W_IFM_BUF)) u_flags (
    .clk       (clk),
    .rstn      (rstn),
    .i_set     (wr_we_r & wr_last_r),
    .i_set_id  (wr_id_r),
    .i_release (i_buf_release),
    .o_flags   (flags_s)
  );

  assign s_if.s_ready   = (state_r == ST_LOAD);
  assign o_buf_we       = wr_we_r;
  assign o_buf_id       = wr_id_r;
  assign o_buf_addr     = wr_addr_r;
  assign o_buf_wdata    = wr_data_r;
  assign o_ifm_buf_done = flags_s;
  assign o_load_busy    = (state_r != ST_IDLE);
  assign o_load_done    = done_r;

endmodule
